fp_divider_par: RTL and testbench

FP_DIVIDER_PAR -- requirements
Module: fp_divider_par

---
 rtl/fp_divider_par_if.sv | 24 ++
 rtl/fp_divider_par.sv | 125 ++++++++++++
 tb/tb_fp_divider_par.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fp_divider_par_if.sv
// fp_divider_par_if: client/divider signal bundle for fp_divider_par.
//   run        client -> divider  operation request, held high until done
//   x, y       client -> divider  dividend / divisor (sign|exponent|fraction)
//   stall      divider -> client  run AND NOT done
//   z          divider -> client  registered quotient
//   divz/ovf/unf divider -> client registered divide-by-zero / overflow / underflow
interface fp_divider_par_if #(
   parameter int unsigned EW = 8,
   parameter int unsigned MW = 23
);
   localparam int unsigned W = 1 + EW + MW;

   logic         run;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         stall;
   logic [W-1:0] z;
   logic         divz;
   logic         ovf;
   logic         unf;

   modport master (output run, x, y, input stall, z, divz, ovf, unf);
   modport slave  (input run, x, y, output stall, z, divz, ovf, unf);
endinterface

// File: rtl/fp_divider_par.sv
// fp_divider_par: iterative restoring floating-point divider, one quotient bit
// per clock, round-to-nearest-even, flush-to-zero on subnormals.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   slave side of fp_divider_par_if (run/x/y in, stall/z/divz/ovf/unf out)
// Latency is MW+4 edges from run rising to stall falling.
module fp_divider_par #(
   parameter int unsigned EW = 8,
   parameter int unsigned MW = 23
) (
   input  logic             clk,
   input  logic             rst,
   fp_divider_par_if.slave  bus
);
   localparam int unsigned W    = 1 + EW + MW;
   localparam int unsigned N    = MW + 3;           // quotient bits
   localparam int unsigned SW   = $clog2(N + 2);    // counter width, holds N+1
   localparam int unsigned RW   = MW + 3;           // partial remainder width
   localparam int unsigned DW   = RW + 1;           // trial difference, with sign
   localparam int unsigned XW   = EW + 2;           // signed working exponent
   localparam int unsigned BIAS = (1 << (EW - 1)) - 1;
   localparam int unsigned EMAX = (1 << EW) - 1;

   logic [SW-1:0] s;
   logic [N-1:0]  q;
   logic [RW-1:0] r;

   logic [RW-1:0] r_cur;
   logic [DW-1:0] diff;
   logic          qbit;
   logic [RW-1:0] r_nxt;
   logic [RW-1:0] r_sh;

   logic [EW-1:0]        xe, ye;
   logic                 sgn;
   logic                 xz, yz, xi, yi;
   logic signed [XW-1:0] e_raw, e_fin;
   logic [MW:0]          sig;
   logic                 rb, st, inc;
   logic [MW+1:0]        sig_r;
   logic [MW-1:0]        frac;
   logic [W-1:0]         z_c;
   logic                 divz_c, ovf_c, unf_c;

   assign bus.stall = bus.run & (s != SW'(N + 1));

   // One restoring step; the first step takes its remainder straight from x.
   always_comb begin
      r_cur = (s == '0) ? RW'({2'b01, bus.x[MW-1:0]}) : r;
      diff  = DW'(r_cur) - DW'({2'b01, bus.y[MW-1:0]});
      qbit  = ~diff[DW-1];
      r_nxt = qbit ? diff[RW-1:0] : r_cur;
      r_sh  = r_nxt << 1;
   end

   // Normalise, round and apply special cases to form the next result.
   always_comb begin
      xe  = bus.x[W-2:MW];
      ye  = bus.y[W-2:MW];
      sgn = bus.x[W-1] ^ bus.y[W-1];
      xz  = (xe == '0);
      yz  = (ye == '0);
      xi  = (xe == '1);
      yi  = (ye == '1);

      e_raw = XW'(xe) - XW'(ye) + XW'(BIAS) - XW'(!q[N-1]);
      sig   = q[N-1] ? q[N-1:2] : q[N-2:1];
      rb    = q[N-1] ? q[1] : q[0];
      st    = (q[N-1] & q[0]) | (r != '0);
      inc   = rb & (st | sig[0]);
      sig_r = {1'b0, sig} + (MW+2)'(inc);
      // On carry-out the low bits are all zero, so the shifted view gives frac = 0.
      frac  = sig_r[MW+1] ? sig_r[MW:1] : sig_r[MW-1:0];
      e_fin = e_raw + XW'(sig_r[MW+1]);

      z_c    = {sgn, EW'(e_fin), frac};
      divz_c = 1'b0;
      ovf_c  = 1'b0;
      unf_c  = 1'b0;

      if ((xz & yz) | (xi & yi)) begin
         z_c = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      end else if (xz) begin
         z_c = {sgn, {(W-1){1'b0}}};
      end else if (yz) begin
         z_c    = {sgn, {EW{1'b1}}, {MW{1'b0}}};
         divz_c = ~xi;
      end else if (xi) begin
         z_c = {sgn, {EW{1'b1}}, {MW{1'b0}}};
      end else if (yi) begin
         z_c = {sgn, {(W-1){1'b0}}};
      end else if (e_fin >= $signed(XW'(EMAX))) begin
         z_c   = {sgn, {EW{1'b1}}, {MW{1'b0}}};
         ovf_c = 1'b1;
      end else if (e_fin <= $signed(XW'(0))) begin
         z_c   = {sgn, {(W-1){1'b0}}};
         unf_c = 1'b1;
      end
   end

   // Iteration counter, quotient/remainder shift registers and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s        <= '0;
         q        <= '0;
         r        <= '0;
         bus.z    <= '0;
         bus.divz <= 1'b0;
         bus.ovf  <= 1'b0;
         bus.unf  <= 1'b0;
      end else if (!bus.run) begin
         s <= '0;
      end else if (s < SW'(N)) begin
         q <= {q[N-2:0], qbit};
         r <= r_sh;
         s <= s + SW'(1);
      end else if (s == SW'(N)) begin
         bus.z    <= z_c;
         bus.divz <= divz_c;
         bus.ovf  <= ovf_c;
         bus.unf  <= unf_c;
         s        <= s + SW'(1);
      end
   end
endmodule

// File: tb/tb_fp_divider_par.sv
// tb_fp_divider_par: directed self-checking bench for fp_divider_par
// (single precision instance plus an EW=5/MW=10 instance).
module tb_fp_divider_par;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cnt;

   fp_divider_par_if #(.EW(8), .MW(23)) bus8 ();
   fp_divider_par_if #(.EW(5), .MW(10)) bus16 ();

   fp_divider_par #(.EW(8), .MW(23)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
   fp_divider_par #(.EW(5), .MW(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for stall to drop on the single-precision instance, counting edges.
   task automatic wait_done8(output int n);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (!bus8.stall) break;
      end
   endtask

   task automatic run8(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] ez, input logic [2:0] ef);
      int n;
      @(negedge clk);
      bus8.x   = xv;
      bus8.y   = yv;
      bus8.run = 1'b1;
      #1;
      chk({tag, "_stall_start"}, 64'(bus8.stall), 64'd1);
      wait_done8(n);
      chk({tag, "_edges"}, 64'(n), 64'd27);
      chk({tag, "_z"}, 64'(bus8.z), 64'(ez));
      chk({tag, "_flags"}, 64'({bus8.divz, bus8.ovf, bus8.unf}), 64'(ef));
      @(negedge clk);
      bus8.run = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      bus8.run  = 1'b0;
      bus8.x    = '0;
      bus8.y    = '0;
      bus16.run = 1'b0;
      bus16.x   = '0;
      bus16.y   = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_z", 64'(bus8.z), 64'd0);
      chk("reset_flags", 64'({bus8.divz, bus8.ovf, bus8.unf}), 64'd0);
      chk("reset_stall_idle", 64'(bus8.stall), 64'd0);
      bus8.run = 1'b1;
      #1;
      chk("reset_stall_run", 64'(bus8.stall), 64'd1);
      bus8.run = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      run8("one_by_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
      run8("one_by_three",32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);
      run8("six_by_m2",   32'h40C00000, 32'hC0000000, 32'hC0400000, 3'b000);
      run8("div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100);
      run8("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000);
      run8("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b010);
      run8("underflow",   32'h00800000, 32'h4B000000, 32'h00000000, 3'b001);
      run8("inf_by_one",  32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000);
      run8("one_by_minf", 32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000);
      run8("mzero_by_one",32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);

      // Result holds after run falls.
      run8("hold_setup",  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_z", 64'(bus8.z), 64'h3EAAAAAB);

      // Run dropped mid-operation: outputs kept, next run takes the full latency.
      @(negedge clk);
      bus8.x   = 32'h40C00000;
      bus8.y   = 32'hC0000000;
      bus8.run = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus8.run = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_z_kept", 64'(bus8.z), 64'h3EAAAAAB);
      chk("abort_s_zero", 64'(dut8.s), 64'd0);
      run8("after_abort", 32'h40C00000, 32'hC0000000, 32'hC0400000, 3'b000);

      // Asynchronous reset at edge 10 of an operation, then resume with run held.
      @(negedge clk);
      bus8.x   = 32'h3F800000;
      bus8.y   = 32'h40400000;
      bus8.run = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_z", 64'(bus8.z), 64'd0);
      chk("rst_s", 64'(dut8.s), 64'd0);
      chk("rst_stall", 64'(bus8.stall), 64'd1);
      @(posedge clk);
      #1;
      chk("rst_s_held", 64'(dut8.s), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      wait_done8(cnt);
      chk("rst_rerun_edges", 64'(cnt), 64'd27);
      chk("rst_rerun_z", 64'(bus8.z), 64'h3EAAAAAB);
      @(negedge clk);
      bus8.run = 1'b0;

      // Half precision: 1.0 / 2.0.
      @(negedge clk);
      bus16.x   = 16'h3C00;
      bus16.y   = 16'h4000;
      bus16.run = 1'b1;
      cnt = 0;
      while (cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
         if (!bus16.stall) break;
      end
      chk("h_edges", 64'(cnt), 64'd14);
      chk("h_z", 64'(bus16.z), 64'h3800);
      chk("h_flags", 64'({bus16.divz, bus16.ovf, bus16.unf}), 64'd0);
      @(negedge clk);
      bus16.run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
